// File: rtl/period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter_if
//  Description : Record bus carrying one completed period measurement
//                (high time, low time, period) with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface period_meter_if #(
  parameter int WIDTH = 16
) ();

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] low_len;
  logic [WIDTH:0]   period;

  // Producer side: the meter drives the record and reads back-pressure.
  modport master (
    output m_valid,
    output high_len,
    output low_len,
    output period,
    input  m_ready
  );

  // Consumer side: firmware or a bench reads the record and drives ready.
  modport slave (
    input  m_valid,
    input  high_len,
    input  low_len,
    input  period,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : period_meter
//  Description : Measures high time, low time and period of a slow periodic
//                single-bit signal in system-clock cycles and emits one record
//                per completed period on a single-entry valid/ready slot.
//                Records arriving while the slot is full are dropped and a
//                sticky overrun flag is raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int WIDTH = 16
) (
  input  wire            clock_in,
  input  wire            reset,
  input  wire            sig_in,
  input  wire            enable,
  period_meter_if.master rec,
  output logic           overrun,
  output logic           timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Synchronizer chain and edge flags
  logic s1;
  logic s2;
  logic s3;
  logic rise;
  logic fall;

  // Measurement state
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] hi_nxt;
  logic             rec_done;
  logic             sat;

  // Output slot
  logic             valid;
  logic [WIDTH-1:0] high_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH:0]   period_q;
  logic             load;
  logic             drop;

  // Bring sig_in into the clock domain; runs regardless of enable so the
  // edge detector is primed as soon as measurement is re-enabled.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Measurement state register, cycle counter and captured high time.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
    end
  end

  // Next-state logic: count phase lengths, hand the high time to the LOW
  // phase, complete a record on the rise that ends LOW, and give up to IDLE
  // when the counter would overflow.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    rec_done  = 1'b0;
    sat       = 1'b0;

    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only a rise starts a measurement, so a partial period seen at
          // start-up or after an abort never produces a record.
          if (rise) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = CNT_ONE;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            hi_nxt    = cnt;
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_LOW;
          end else if (cnt == CNT_MAX) begin
            sat       = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        ST_LOW: begin
          if (rise) begin
            rec_done  = 1'b1;
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_HIGH;
          end else if (cnt == CNT_MAX) begin
            sat       = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A record may enter the slot when it is empty or being drained this cycle.
  assign load = rec_done & (~valid | rec.m_ready);
  assign drop = rec_done & ~load;

  // Single-entry output slot with sticky overrun and registered timeout.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      valid    <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (load) begin
        valid    <= 1'b1;
        high_q   <= hi;
        low_q    <= cnt;
        // Extended by one bit so the sum cannot wrap.
        period_q <= {1'b0, hi} + {1'b0, cnt};
      end else if (valid && rec.m_ready) begin
        valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end

      timeout <= sat;
    end
  end

  assign rec.m_valid  = valid;
  assign rec.high_len = high_q;
  assign rec.low_len  = low_q;
  assign rec.period   = period_q;

endmodule
`default_nettype wire

// File: doc/period_meter.md
# period_meter

Measures the high time, low time and period of a slow, single-bit periodic signal (typically a divided clock) in units of the system clock. It sits directly downstream of the clock divider: the divider's output is fed to `sig_in`, and each completed period is emitted as one record on a valid/ready output. Firmware and testbenches use it to check divider ratios and duty cycle. Records that find the output slot occupied are dropped and flagged.

## Interface

Parameters:
- `WIDTH`, default 16: width of the high/low length counters.

Ports:
- `clock_in`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sig_in`  input  1  measured signal; may be asynchronous to `clock_in`.
- `enable`  input  1  1 = measure; 0 = abort and hold in IDLE.
- `m_valid`  output  1  record available.
- `m_ready`  input  1  consumer accepts the record when `m_valid && m_ready`.
- `high_len`  output  WIDTH  cycles `sig_in` was high.
- `low_len`  output  WIDTH  cycles `sig_in` was low.
- `period`  output  WIDTH+1  `high_len + low_len`.
- `overrun`  output  1  sticky; a record was dropped.
- `timeout`  output  1  one-cycle pulse; a counter saturated.

## Operation

- **Synchronizer:**
  - 3-flop chain s1 <= sig_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The chain always runs, independent of `enable`.
- **FSM states:** IDLE, HIGH, LOW. One counter `cnt` (WIDTH bits) and one holding register `hi`.
  - IDLE: on rise -> HIGH, cnt <= 1.
  - HIGH:
    - On fall: hi <= cnt, cnt <= 1, -> LOW.
    - Otherwise cnt <= cnt+1.
  - LOW:
    - On rise: complete a record with high = hi, low = cnt; then cnt <= 1, -> HIGH.
    - Otherwise cnt <= cnt+1.
  - Saturation: in HIGH or LOW, if cnt == 2^WIDTH-1 and no edge occurs this cycle -> IDLE. `timeout` pulses for 1 cycle. No record is produced.
  - `enable` = 0: state <= IDLE and cnt <= 0 every cycle. The output slot, `m_valid` and `overrun` are unaffected.
- **Counting rule:** a pulse held for H system cycles gives cnt == H at its terminating edge.
- **First record:** only after a full rise -> fall -> rise sequence. A partial period at start-up or after IDLE is discarded.
- **Output slot (single register):**
  - A completed record loads if `!m_valid || m_ready` in that same cycle. Then `m_valid` <= 1 and `high_len`/`low_len`/`period` update.
  - Otherwise the record is dropped, `overrun` <= 1, and the slot contents are unchanged.
  - When `m_valid && m_ready` and no load occurs, `m_valid` <= 0. Data outputs keep their last value.
  - Load and accept in the same cycle: the new record replaces the old one and `m_valid` stays 1.
  - `period` is computed at load time at full WIDTH+1 width, so it never wraps.
- `overrun` clears only on `reset`.

## Timing

- **Reset** (synchronous, takes effect at the next clock edge):
  - s1/s2/s3 = 0, state = IDLE, cnt = 0, hi = 0.
  - `m_valid` = 0, `high_len` = 0, `low_len` = 0, `period` = 0, `overrun` = 0, `timeout` = 0.
  - Reset mid-record discards the partial measurement. Reset overrides `enable`.
- **Latency:**
  - The rise or fall flag is true in the cycle after the 2nd clock edge at which `sig_in` is sampled at its new level.
  - A record appears (`m_valid` = 1) after the 3rd such edge of the terminating rising edge.
- **Throughput:** one record per period of `sig_in`.
  - Periods must be at least 4 system cycles, with high and low each at least 2.
  - Shorter pulses may be missed; this is not checked.
- `timeout` is registered and asserts on the edge that forces IDLE.
- `m_ready` is sampled on the same edge as the load decision. No combinational path from `m_ready` to any output.

## Test plan

- **Divide-by-2 input:** `sig_in` from a divider with SCALE = 2 (2 cycles high, 2 low), `m_ready` = 1 -> from the second rise on, one record every 4 cycles with high_len = 2, low_len = 2, period = 4. No overrun.
- **Asymmetric duty:** `sig_in` 5 cycles high, 3 low, repeated -> high_len = 5, low_len = 3, period = 8. Check the 3-edge latency from the rising `sig_in` sample to `m_valid`.
- **Backpressure:** 2/2 input, `m_ready` = 0 across two completed periods -> first record (2, 2, 4) held, second dropped, `overrun` = 1. Raise `m_ready` for 1 cycle -> `m_valid` falls. Next record loads. `overrun` stays 1.
- **Accept and load same cycle:** time `m_ready` = 1 to coincide with a completing record -> `m_valid` stays 1, the new values appear, `overrun` = 0.
- **Saturation (WIDTH = 4):** `sig_in` rises, then stays high for 30 cycles -> `timeout` pulses once when cnt reaches 15, no record, state IDLE. The following rise -> fall -> rise produces a correct record.
- **Abort mid-period:**
  - Drop `enable` mid-HIGH for 3 cycles, then restore -> no record from the aborted period. The next full period measures correctly.
  - Assert `reset` mid-LOW -> all outputs return to 0 on the next edge.
